seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Runtime-programmable serial bit-pattern detector with a Moore-style registered output. It generalises the team's fixed-pattern sequence FSMs to any pattern of 1..MAX_LEN bits, adds selectable overlap or non-overlap matching and input qualification, and keeps a saturating match counter. It sits after a serial bit source as a reusable detector for framing and sync words.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN)+1: width of length fields (derived).

- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  in_bit is consumed on this edge.
- in_bit  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe that latches the cfg_* fields.
- cfg_pattern  in  MAX_LEN  pattern. pattern[len-1] is the oldest bit and pattern[0] the newest.
- cfg_len  in  LEN_W  pattern length. Legal range is 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_count.
- det  out  1  Moore match flag. High exactly while the FSM is in MATCH.
- cfg_ok  out  1  a valid configuration is loaded (state ≠ UNCFG).
- cfg_err  out  1  one-cycle pulse on a rejected cfg_load.
- match_count  out  CNT_W  saturating count of matches.

## Operation
- States:
  - UNCFG: after reset. in_valid is ignored.
  - HUNT
  - MATCH
- Datapath:
  - hist (MAX_LEN shift register; the newest bit enters at bit 0).
  - fill (0..len, the number of valid history bits).
  - Latched pattern, len and overlap.
- Accepted bit (state ≠ UNCFG and in_valid):
  - hist_n = {hist, in_bit}.
  - fill_n = min(fill+1, len).
  - hit = (fill_n == len) and hist_n[len-1:0] == pattern[len-1:0]. Bits above len are don't-care.
  - If hit: go to MATCH. fill becomes len when overlap=1, and 0 when overlap=0. match_count increments, saturating at 2^CNT_W−1.
  - If no hit: go to HUNT.
- MATCH is left only on the next accepted bit. That bit can re-enter MATCH if it completes a further hit.
- Cycles without in_valid change nothing: det, hist and fill all hold.
- cfg_load with 1 ≤ cfg_len ≤ MAX_LEN:
  - Latch the cfg_* fields.
  - Clear hist and fill.
  - Go to HUNT, so det drops.
  - match_count is untouched.
- cfg_load with cfg_len = 0 or cfg_len > MAX_LEN:
  - Ignored entirely; state and configuration are unchanged.
  - cfg_err pulses on the next cycle.
- Simultaneous events:
  - cfg_load together with in_valid: cfg_load wins and the bit is discarded.
  - cnt_clr together with a hit: the clear wins and match_count = 0. The state transition still happens.
- Reset values:
  - state = UNCFG.
  - hist, fill, pattern, len and overlap are all 0.
  - det, cfg_ok, cfg_err and match_count are all 0.
- Reset asserted mid-stream: all partial history is lost. A fresh cfg_load is required before any further detection.

## Timing
- det, cfg_ok and match_count are registered and driven from flops only, with no combinational path from any input.
- Latency: a bit accepted at edge k that completes a match makes det = 1 and match_count updated from edge k onward. Both are visible in the cycle after k.
- det stays high until the edge that accepts the next valid bit.
- cfg_ok goes high from the edge that accepts a valid cfg_load.
- The first bit after that edge can be accepted on the following cycle.
- cfg_err is high for exactly the one cycle after the rejected edge.
- Throughput is one bit per clock.

## Structure
- Shared package seq_det_pkg holds:
  - The state enum (UNCFG, HUNT, MATCH).
  - A helper function for computing the length mask.
- One sub-module, seq_match_cmp:
  - Combinational masked compare of hist_n against pattern under len.
  - Reusable by a future multi-pattern variant.
- The top level owns the FSM, the shift register, fill and the counter.

## Test plan
- Overlap:
  - Stimulus: reset, then load pattern 4'b1010 with len=4 and overlap=1. Stream 1,0,1,0,1,0 with in_valid continuously high.
  - Required response: det is high after bit 4 and after bit 6, low after bit 5, and match_count = 2.
- Non-overlap:
  - Stimulus: same load with overlap=0. Stream 1,0,1,0,1,0,1,0.
  - Required response: det is high only after bits 4 and 8, and match_count = 2.
- Gaps, bad config and load priority:
  - After a match, hold in_valid=0 for 5 cycles: det stays 1.
  - cfg_load with cfg_len=0: cfg_err pulses for 1 cycle, det and configuration are unchanged.
  - cfg_load together with in_valid: the bit is dropped and fill = 0.
- Saturation:
  - Stimulus: CNT_W=2, load pattern 1 with len=1 and overlap=1, stream five 1s.
  - Required response: match_count is 3 and holds. det stays high throughout.
  - Then apply cnt_clr together with a hit: match_count = 0 and det = 1.
- Mid-stream reset:
  - Stimulus: stream 1,0,1, then pulse rst low, then drive 0 with in_valid=1 before any load.
  - Required response: det = 0, cfg_ok = 0, match_count = 0. No match occurs until a cfg_load is applied.
- Full length:
  - Stimulus: MAX_LEN=8, pattern 8'hA5 with len=8. Stream 7 pattern bits, then a wrong bit, then the full pattern.
  - Required response: exactly one det assertion, after the last pattern bit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector family.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    HUNT  = 2'd1,
    MATCH = 2'd2
  } state_t;

  // One bit of the length mask: positions below len take part in the compare.
  function automatic logic in_mask(input int unsigned idx, input int unsigned len);
    return idx < len;
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Data, configuration and status signals of the pattern detector.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
);
  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               det;
  logic               cfg_ok;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  det, cfg_ok, cfg_err, match_count
  );

  modport slave (
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output det, cfg_ok, cfg_err, match_count
  );
endinterface

// File: rtl/seq_match_cmp.sv
// Masked compare of a bit history window against a pattern of programmable length.
module seq_match_cmp
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               eq
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = in_mask(i, 32'(len));
    end
    eq = (((hist ^ pattern) & mask) == '0);
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with Moore match flag and saturating counter.
//   state | meaning
//   UNCFG | no valid configuration since reset; input bits ignored
//   HUNT  | configured, last accepted bit did not complete a match
//   MATCH | last accepted bit completed a match; det high
module seq_detect_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input logic               clk,
  input logic               rst,
  seq_detect_prog_if.slave  bus
);

  state_t             state_q, state_n;
  // The oldest bit of a full window is never compared again, so one bit less is kept.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               det_q, cfg_ok_q;

  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic               cfg_valid;
  logic               accept;
  logic               pat_eq;
  logic               hit;

  assign hist_n    = {hist_q, bus.in_bit};
  assign fill_n    = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
  assign cfg_valid = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
  assign accept    = (state_q != UNCFG) && bus.in_valid && !bus.cfg_load;
  assign hit       = accept && (fill_n == len_q) && pat_eq;

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist    (hist_n),
    .pattern (pat_q),
    .len     (len_q),
    .eq      (pat_eq)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNCFG;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (bus.cfg_load) begin
      if (cfg_valid) begin
        state_n = HUNT;
        pat_d   = bus.cfg_pattern;
        len_d   = bus.cfg_len;
        ovl_d   = bus.cfg_overlap;
        hist_d  = '0;
        fill_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (accept) begin
      hist_d = hist_n[MAX_LEN-2:0];
      if (hit) begin
        state_n = MATCH;
        fill_d  = ovl_q ? len_q : '0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_n = HUNT;
        fill_d  = fill_n;
      end
    end

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q   <= '0;
      fill_q   <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      ovl_q    <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      det_q    <= 1'b0;
      cfg_ok_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      det_q    <= (state_n == MATCH);
      cfg_ok_q <= (state_n != UNCFG);
    end
  end

  assign bus.det         = det_q;
  assign bus.cfg_ok      = cfg_ok_q;
  assign bus.cfg_err     = err_q;
  assign bus.match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: two instances (8-bit and 2-bit counters) against a queue model.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_bit, cfg_load, cfg_overlap, cnt_clr;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;

  int total = 0;
  int bad   = 0;
  bit go    = 0;

  always #5 clk = ~clk;

  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(8)) bus_a ();
  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2)) bus_b ();

  assign bus_a.in_valid    = in_valid;
  assign bus_a.in_bit      = in_bit;
  assign bus_a.cfg_load    = cfg_load;
  assign bus_a.cfg_pattern = cfg_pattern;
  assign bus_a.cfg_len     = cfg_len;
  assign bus_a.cfg_overlap = cfg_overlap;
  assign bus_a.cnt_clr     = cnt_clr;
  assign bus_b.in_valid    = in_valid;
  assign bus_b.in_bit      = in_bit;
  assign bus_b.cfg_load    = cfg_load;
  assign bus_b.cfg_pattern = cfg_pattern;
  assign bus_b.cfg_len     = cfg_len;
  assign bus_b.cfg_overlap = cfg_overlap;
  assign bus_b.cnt_clr     = cnt_clr;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: keep the usable bits since the last load/consuming match, compare the newest len of them.
  bit       m_cfgd, m_ovl, m_det, m_err, m_hit;
  bit [7:0] m_pat;
  int       m_len, m_cnt8, m_cnt2;
  bit       q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cfgd = 0; m_ovl = 0; m_det = 0; m_err = 0;
      m_pat = '0; m_len = 0; m_cnt8 = 0; m_cnt2 = 0;
      q.delete();
    end else begin
      m_err = 0;
      if (cfg_load) begin
        if (cfg_len >= 1 && cfg_len <= 8) begin
          m_cfgd = 1; m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
          m_det = 0;
          q.delete();
        end else begin
          m_err = 1;
        end
      end else if (m_cfgd && in_valid) begin
        q.push_back(in_bit);
        if (q.size() > m_len) void'(q.pop_front());
        m_hit = (q.size() == m_len);
        if (m_hit)
          for (int j = 0; j < m_len; j++)
            if (q[j] != m_pat[m_len-1-j]) m_hit = 0;
        m_det = m_hit;
        if (m_hit) begin
          if (!m_ovl) q.delete();
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
      if (cnt_clr) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("det_a", int'(bus_a.det), int'(m_det));
      chk("det_b", int'(bus_b.det), int'(m_det));
      chk("cfg_ok_a", int'(bus_a.cfg_ok), int'(m_cfgd));
      chk("cfg_ok_b", int'(bus_b.cfg_ok), int'(m_cfgd));
      chk("cfg_err_a", int'(bus_a.cfg_err), int'(m_err));
      chk("cfg_err_b", int'(bus_b.cfg_err), int'(m_err));
      chk("count_a", int'(bus_a.match_count), m_cnt8);
      chk("count_b", int'(bus_b.match_count), m_cnt2);
    end
  end

  task automatic step(input logic v, input logic b, input logic clr);
    in_valid = v; in_bit = b; cnt_clr = clr;
    @(posedge clk); #1;
    in_valid = 0; in_bit = 0; cnt_clr = 0; cfg_load = 0;
  endtask

  task automatic load(input logic [7:0] pat, input int len, input logic ovl,
                      input logic v, input logic b);
    cfg_pattern = pat; cfg_len = 4'(len); cfg_overlap = ovl; cfg_load = 1;
    step(v, b, 0);
  endtask

  task automatic stream_chk(input string name, input logic [15:0] bits,
                            input logic [15:0] dets, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1, bits[i], 0);
      chk(name, int'(bus_a.det), int'(dets[i]));
    end
  endtask

  int ndet;
  logic [15:0] full_seq;

  initial begin
    rst = 0;
    in_valid = 0; in_bit = 0; cfg_load = 0; cfg_overlap = 0; cnt_clr = 0;
    cfg_pattern = '0; cfg_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_det", int'(bus_a.det), 0);
    chk("rst_cfg_ok", int'(bus_a.cfg_ok), 0);
    chk("rst_cfg_err", int'(bus_a.cfg_err), 0);
    chk("rst_count", int'(bus_a.match_count), 0);
    rst = 1;
    go  = 1;

    step(1, 1, 0);
    chk("uncfg_ignored", int'(bus_a.det), 0);

    // Overlap: 1010 over 101010 -> hits after bits 4 and 6
    load(8'b0000_1010, 4, 1, 0, 0);
    chk("load_cfg_ok", int'(bus_a.cfg_ok), 1);
    stream_chk("ovl_det", 16'b10_1010, 16'b00_0101, 6);
    chk("ovl_count", int'(bus_a.match_count), 2);

    // Non-overlap: hits after bits 4 and 8 only
    step(0, 0, 1);
    load(8'b0000_1010, 4, 0, 0, 0);
    stream_chk("novl_det", 16'b1010_1010, 16'b0001_0001, 8);
    chk("novl_count", int'(bus_a.match_count), 2);

    // Gaps hold det
    repeat (5) step(0, 0, 0);
    chk("gap_det", int'(bus_a.det), 1);

    // Rejected loads
    load(8'hFF, 0, 1, 1, 0);
    chk("bad0_err", int'(bus_a.cfg_err), 1);
    chk("bad0_det", int'(bus_a.det), 1);
    step(0, 0, 0);
    chk("bad0_err_gone", int'(bus_a.cfg_err), 0);
    load(8'hFF, 9, 1, 0, 0);
    chk("bad9_err", int'(bus_a.cfg_err), 1);
    stream_chk("cfg_kept_det", 16'b1010, 16'b0001, 4);
    chk("cfg_kept_count", int'(bus_a.match_count), 3);

    // Load wins over a simultaneous bit
    load(8'h01, 1, 1, 1, 1);
    chk("load_prio_det", int'(bus_a.det), 0);
    step(1, 1, 0);
    chk("len1_det", int'(bus_a.det), 1);

    // Saturation on the 2-bit counter
    step(0, 0, 1);
    repeat (5) step(1, 1, 0);
    chk("sat_count_b", int'(bus_b.match_count), 3);
    chk("sat_count_a", int'(bus_a.match_count), 5);
    chk("sat_det", int'(bus_b.det), 1);
    step(1, 1, 1);
    chk("clr_hit_count_b", int'(bus_b.match_count), 0);
    chk("clr_hit_count_a", int'(bus_a.match_count), 0);
    chk("clr_hit_det", int'(bus_b.det), 1);

    // Mid-stream reset
    load(8'b0000_1010, 4, 1, 0, 0);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    rst = 0;
    #2;
    rst = 1;
    chk("mrst_det", int'(bus_a.det), 0);
    chk("mrst_cfg_ok", int'(bus_a.cfg_ok), 0);
    chk("mrst_count", int'(bus_a.match_count), 0);
    step(1, 0, 0);
    chk("mrst_bit_det", int'(bus_a.det), 0);
    stream_chk("mrst_nomatch", 16'b1010, 16'b0000, 4);

    // Full length: 7 pattern bits, a wrong bit, then A5 in full
    load(8'hA5, 8, 0, 0, 0);
    full_seq = 16'b1010_0100_1010_0101;
    ndet = 0;
    for (int i = 15; i >= 0; i--) begin
      step(1, full_seq[i], 0);
      if (bus_a.det) ndet++;
    end
    chk("full_det_count", ndet, 1);
    chk("full_det_last", int'(bus_a.det), 1);
    chk("full_count", int'(bus_a.match_count), 1);

    step(0, 0, 0);
    go = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
